// File: rtl/contador_sincrono_decrescente.sv
// Synchronous down counter modulo MODULO with parallel load, one-shot stop at zero
// and a registered borrow pulse on wrap-around.
module contador_sincrono_decrescente #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             one_shot,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             borrow,
    output logic             done
);

    typedef enum logic {
        COUNT = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULO - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] q_next;
    logic             borrow_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= COUNT;
            q      <= TOP;
            borrow <= 1'b0;
        end else begin
            state  <= state_next;
            q      <= q_next;
            borrow <= borrow_next;
        end
    end

    // Load wins over everything; one_shot is only consulted when q is already 0.
    always_comb begin
        state_next  = state;
        q_next      = q;
        borrow_next = 1'b0;
        if (load) begin
            q_next     = (d > TOP) ? TOP : d;
            state_next = COUNT;
        end else if (state == DONE) begin
            q_next = '0;
        end else if (en) begin
            if (q == '0) begin
                if (one_shot) begin
                    q_next     = '0;
                    state_next = DONE;
                end else begin
                    q_next      = TOP;
                    borrow_next = 1'b1;
                end
            end else begin
                q_next = q - WIDTH'(1);
            end
        end
    end

    assign zero = (q == '0);
    assign done = (state == DONE);

endmodule

// File: doc/contador_sincrono_decrescente.md
CONTADOR_SINCRONO_DECRESCENTE -- requirements
Module: contador_sincrono_decrescente

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits.
REQ-002 Parameter MODULO, default 16: count range is MODULO-1 down to 0; legal range 2..2^WIDTH.
REQ-003 Port clk, input, 1: single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1: reset; asynchronous, active-high.
REQ-005 Port en, input, 1: count enable.
REQ-006 Port load, input, 1: synchronous parallel load strobe.
REQ-007 Port d, input, WIDTH: value to load.
REQ-008 Port one_shot, input, 1: 1 = stop at 0, 0 = wrap around.
REQ-009 Port q, output, WIDTH: current count (registered).
REQ-010 Port zero, output, 1: high while q == 0 (combinational from q).
REQ-011 Port borrow, output, 1: registered one-cycle pulse on wrap from 0 to MODULO-1.
REQ-012 Port done, output, 1: high while the state machine is in DONE.

Function
REQ-013 The block SHALL hold a two-state FSM: COUNT and DONE.
REQ-014 In COUNT with en=1 and load=0, q SHALL decrement by 1 each rising edge.
REQ-015 In COUNT with en=0 and load=0, q SHALL hold its value.
REQ-016 With one_shot=0, en=1, load=0 and q == 0, next q SHALL be MODULO-1 and borrow SHALL be 1 for exactly that next cycle.
REQ-017 borrow SHALL be 0 in every cycle not immediately following a wrap.
REQ-018 With one_shot=1, en=1, load=0 and q == 0, q SHALL stay 0, the FSM SHALL enter DONE, and borrow SHALL stay 0.
REQ-019 In DONE, q SHALL hold 0 and done SHALL be 1, regardless of en and one_shot.
REQ-020 load=1 SHALL take priority over en in both states.
REQ-021 load=1 SHALL set next q to d when d <= MODULO-1, otherwise to MODULO-1 (saturation).
REQ-022 load=1 SHALL move the FSM to COUNT and clear borrow on the next cycle.
REQ-023 When load=1 with d=0 and one_shot=1, next q SHALL be 0 with the FSM in COUNT, and DONE SHALL follow one enabled cycle later.
REQ-024 Changing one_shot mid-count SHALL affect only the next q==0 decision; it SHALL have no effect on the current value.
REQ-025 Arithmetic SHALL be modulo MODULO; q SHALL never hold a value >= MODULO.

Reset
REQ-026 While rst=1, regardless of clk: q = MODULO-1, FSM = COUNT, borrow = 0, done = 0.
REQ-027 Assertion of rst mid-count SHALL take effect immediately without waiting for a clock edge.
REQ-028 After rst deasserts, the first decrement SHALL occur on the first rising edge with en=1.

Verification
REQ-029 rst pulse 10 ns, then en=1, one_shot=0 for 17 cycles -> q = 15,14,...,1,0,15,14; borrow=1 only in the cycle q first returns to 15.
REQ-030 Stop-at-zero: en=1, one_shot=1 from q=15 -> q reaches 0, done=1 and zero=1 are held; q stays 0 over 5 further cycles with en=1; borrow never asserts.
REQ-031 Load and saturation: load=1 with d=9 and en=1 -> next q=9. Then with MODULO=10, load d=13 -> q=9. Then en=1 -> q=8.
REQ-032 Leaving DONE: in DONE, load=1 with d=3 -> q=3, done=0. Then 3 enabled cycles -> q = 2,1,0. Next enabled cycle -> done=1.
REQ-033 Asynchronous reset: wait for q==3, assert rst between clock edges -> q=15 before the next edge. Deassert rst -> counting resumes at 14.
REQ-034 Hold: en=0 for 4 cycles at q=7 -> q stays 7, borrow=0, done=0.
